// File: rtl/sap_ram_if.sv
// W-bus / MAR / programming-port bundle for the SAP memory.
// The master side drives addresses, data and strobes; the slave side is the RAM.
interface sap_ram_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] BusIn;
  logic              RAMIn;
  logic              RAMOut;
  logic [DATA_W-1:0] BusOut;
  logic              BusOE;
  logic              prog_mode;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_valid;
  logic              prog_ready;
  logic              busy;

  modport master (
    output Addr, BusIn, RAMIn, RAMOut, prog_mode, prog_addr, prog_data, prog_valid,
    input  BusOut, BusOE, prog_ready, busy
  );

  modport slave (
    input  Addr, BusIn, RAMIn, RAMOut, prog_mode, prog_addr, prog_data, prog_valid,
    output BusOut, BusOE, prog_ready, busy
  );
endinterface

// File: rtl/sap_ram.sv
// SAP data/program memory: W-bus read/write from the MAR address, zero-fill sweep
// after reset, and a two-cycle handshaked programming port.
module sap_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  sap_ram_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {CLEAR, RUN, PROG, PACK} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // A single write port shared by the sweep, the W-bus and the programming port;
  // reset suppresses every write on its edge.
  always_comb begin
    we    = 1'b0;
    waddr = bus.Addr;
    wdata = bus.BusIn;
    if (!rst) begin
      case (state)
        CLEAR: begin
          we    = 1'b1;
          waddr = cnt;
          wdata = '0;
        end
        RUN:  we = bus.RAMIn;
        PROG: begin
          we    = bus.prog_valid;
          waddr = bus.prog_addr;
          wdata = bus.prog_data;
        end
        default: we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= CLEAR;
      cnt            <= '0;
      bus.BusOut     <= '0;
      bus.BusOE      <= 1'b0;
      bus.prog_ready <= 1'b0;
      bus.busy       <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          bus.BusOut     <= '0;
          bus.BusOE      <= 1'b0;
          bus.prog_ready <= 1'b0;
          cnt            <= cnt + 1'b1;
          if (&cnt) begin
            state    <= RUN;
            bus.busy <= 1'b0;
          end
        end
        RUN: begin
          // Reads see pre-write contents because mem updates on the same edge.
          if (bus.prog_mode) begin
            state          <= PROG;
            bus.prog_ready <= 1'b1;
            bus.BusOut     <= '0;
            bus.BusOE      <= 1'b0;
          end else if (bus.RAMOut) begin
            bus.BusOut <= mem[bus.Addr];
            bus.BusOE  <= 1'b1;
          end else begin
            bus.BusOut <= '0;
            bus.BusOE  <= 1'b0;
          end
        end
        PROG: begin
          bus.BusOut <= '0;
          bus.BusOE  <= 1'b0;
          if (bus.prog_valid) begin
            state          <= PACK;
            bus.prog_ready <= 1'b0;
          end else if (!bus.prog_mode) begin
            state          <= RUN;
            bus.prog_ready <= 1'b0;
          end
        end
        PACK: begin
          bus.BusOut <= '0;
          bus.BusOE  <= 1'b0;
          if (bus.prog_mode) begin
            state          <= PROG;
            bus.prog_ready <= 1'b1;
          end else begin
            state          <= RUN;
            bus.prog_ready <= 1'b0;
          end
        end
        default: begin
          state    <= CLEAR;
          cnt      <= '0;
          bus.busy <= 1'b1;
        end
      endcase
    end
  end
endmodule
